// File: rtl/jtframe_dwnld_banks.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : jtframe_dwnld_banks
// Description : Routes the ioctl download byte stream to a multi-bank SDRAM
//               programming port through a small write FIFO. Bytes beyond
//               PROM_START are sent to a separate PROM write strobe instead.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dwnld_banks #(
    parameter int          BANKS      = 4,
    parameter logic [24:0] BA1_START  = 25'h10_0000,
    parameter logic [24:0] BA2_START  = 25'h20_0000,
    parameter logic [24:0] BA3_START  = 25'h30_0000,
    parameter logic [24:0] PROM_START = 25'h1FF_FFFF,
    parameter logic        SWAB       = 1'b0,
    parameter int          FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        prom_we,
    output logic [24:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic        dwnld_busy,
    output logic        overflow
);

    // FIFO entry layout: {bank[1:0], word address[21:0], byte[7:0], mask[1:0]}
    localparam int c_depth   = 1 << FIFO_AW;
    localparam int c_entry_w = 34;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_load;

    logic [1:0]            w_bank;
    logic [24:0]           w_base;
    logic [24:0]           w_off;
    logic [1:0]            w_mask;
    logic                  w_is_prom;
    logic                  w_push_req;
    logic                  w_prom_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_empty;
    logic                  w_full;
    logic [c_entry_w-1:0]  w_entry;
    logic [c_entry_w-1:0]  w_head;
    logic                  w_unused;

    logic [c_entry_w-1:0]  r_mem [0:c_depth-1];
    logic [FIFO_AW:0]      r_wr_ptr;
    logic [FIFO_AW:0]      r_rd_ptr;
    logic                  r_dl_prev;
    logic                  r_overflow;
    logic                  r_prom_we;
    logic [24:0]           r_prom_addr;
    logic [7:0]            r_prom_data;
    logic [21:0]           r_prog_addr;
    logic [15:0]           r_prog_data;
    logic [1:0]            r_prog_mask;
    logic [1:0]            r_prog_ba;

    // Bank decode: later (higher) banks override earlier matches
    always_comb begin
        w_bank = 2'd0;
        w_base = 25'd0;
        if (BANKS > 1 && ioctl_addr >= BA1_START) begin
            w_bank = 2'd1;
            w_base = BA1_START;
        end
        if (BANKS > 2 && ioctl_addr >= BA2_START) begin
            w_bank = 2'd2;
            w_base = BA2_START;
        end
        if (BANKS > 3 && ioctl_addr >= BA3_START) begin
            w_bank = 2'd3;
            w_base = BA3_START;
        end
    end

    assign w_off      = ioctl_addr - w_base;
    assign w_mask     = (w_off[0] ^ SWAB) ? 2'b01 : 2'b10;
    assign w_entry    = {w_bank, w_off[22:1], ioctl_data, w_mask};
    assign w_unused   = &{1'b0, w_off[24:23]};

    assign w_is_prom  = ioctl_addr >= PROM_START;
    assign w_push_req = ioctl_wr & downloading & ~w_is_prom;
    assign w_prom_req = ioctl_wr & downloading & w_is_prom;

    // Full when the pointers differ only in their wrap bit
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                        (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

    // The head entry stays in the FIFO until the controller acknowledges it,
    // so a pop frees a slot for a push arriving in the same cycle.
    assign w_pop      = (r_state == S_WAIT) & prog_rdy;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_head     = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    // FIFO storage, no reset needed as validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_entry;
        end
    end

    // FIFO pointers with natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky overflow flag, cleared when a new download window opens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_prev  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_dl_prev <= downloading;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (downloading && !r_dl_prev) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // PROM-region bytes leave as a registered one-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prom_we   <= 1'b0;
            r_prom_addr <= '0;
            r_prom_data <= '0;
        end else begin
            r_prom_we <= w_prom_req;
            if (w_prom_req) begin
                r_prom_addr <= ioctl_addr - PROM_START;
                r_prom_data <= ioctl_data;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: issue the head entry, then hold until acknowledged
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_WAIT;
                    w_load      = 1'b1;
                end
            end
            S_WAIT: begin
                if (prog_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Programming port registers, loaded once per write and held during WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_ba   <= '0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_prog_mask <= '0;
        end else if (w_load) begin
            r_prog_ba   <= w_head[33:32];
            r_prog_addr <= w_head[31:10];
            r_prog_data <= {2{w_head[9:2]}};
            r_prog_mask <= w_head[1:0];
        end
    end

    assign prog_we    = (r_state == S_WAIT);
    assign prog_ba    = r_prog_ba;
    assign prog_addr  = r_prog_addr;
    assign prog_data  = r_prog_data;
    assign prog_mask  = r_prog_mask;
    assign prom_we    = r_prom_we;
    assign prom_addr  = r_prom_addr;
    assign prom_data  = r_prom_data;
    assign overflow   = r_overflow;
    assign dwnld_busy = downloading | ~w_empty | (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jtframe_dwnld_banks.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_jtframe_dwnld_banks
// Description : Directed plus randomized bench for jtframe_dwnld_banks with a
//               queue-based reference of the expected SDRAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_dwnld_banks;

    localparam logic [24:0] PROM = 25'h080_0000;
    localparam int          CAP  = 4;

    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] wa;
        logic [7:0]  d;
        logic [1:0]  m;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        prog_rdy = 1'b0;

    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        prom_we;
    logic [24:0] prom_addr;
    logic [7:0]  prom_data;
    logic        dwnld_busy;
    logic        overflow;

    logic [21:0] b1_prog_addr;
    logic [15:0] b1_prog_data;
    logic [1:0]  b1_prog_mask;
    logic [1:0]  b1_prog_ba;
    logic        b1_prog_we;
    logic        b1_prom_we;
    logic [24:0] b1_prom_addr;
    logic [7:0]  b1_prom_data;
    logic        b1_dwnld_busy;
    logic        b1_overflow;

    int  checks = 0;
    int  errors = 0;
    wr_t q[$];
    wr_t h;
    logic [24:0] starts [4];

    always #5 clk = ~clk;

    jtframe_dwnld_banks #(.BANKS(4), .PROM_START(PROM)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_ba(prog_ba), .prog_we(prog_we), .prog_rdy(prog_rdy),
        .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
        .dwnld_busy(dwnld_busy), .overflow(overflow)
    );

    jtframe_dwnld_banks #(.BANKS(1), .PROM_START(PROM)) dut1 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(b1_prog_addr), .prog_data(b1_prog_data), .prog_mask(b1_prog_mask),
        .prog_ba(b1_prog_ba), .prog_we(b1_prog_we), .prog_rdy(prog_rdy),
        .prom_we(b1_prom_we), .prom_addr(b1_prom_addr), .prom_data(b1_prom_data),
        .dwnld_busy(b1_dwnld_busy), .overflow(b1_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected write for a byte: pick the highest bank whose start is reached
    function automatic wr_t ref_wr(input logic [24:0] a, input logic [7:0] d, input int banks);
        wr_t r;
        int b = 0;
        logic [24:0] off;
        for (int i = 0; i < banks; i++) if (a >= starts[i]) b = i;
        off  = a - starts[b];
        r.ba = 2'(b);
        r.wa = 22'(off / 2);
        r.d  = d;
        r.m  = (off % 2 == 1) ? 2'b01 : 2'b10;
        return r;
    endfunction

    // Called at a negedge; presents one byte for one clock and returns at the next negedge
    task automatic send(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
        if (downloading && a >= PROM) begin
            chk("prom_we", prom_we, 1);
            chk("prom_addr", prom_addr, a - PROM);
            chk("prom_data", prom_data, d);
        end else begin
            chk("prom_we_idle", prom_we, 0);
            if (downloading && q.size() < CAP) q.push_back(ref_wr(a, d, 4));
        end
    endtask

    // Waits (bounded) for a write request, checks it against the model, acknowledges it
    task automatic serve(input logic last_busy_check);
        for (int i = 0; i < 20 && !prog_we; i++) @(negedge clk);
        if (!prog_we) begin
            chk("we_timeout", 0, 1);
            return;
        end
        if (q.size() == 0) begin
            chk("unexpected_write", 1, 0);
            return;
        end
        h = q.pop_front();
        chk("prog_ba", prog_ba, h.ba);
        chk("prog_addr", prog_addr, h.wa);
        chk("prog_data", prog_data, {h.d, h.d});
        chk("prog_mask", prog_mask, h.m);
        if (last_busy_check) chk("busy_before_rdy", dwnld_busy, 1);
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_rdy = 1'b0;
        chk("we_low_gap", prog_we, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] a;
        int n, kind;
        starts[0] = 25'h000000;
        starts[1] = 25'h100000;
        starts[2] = 25'h200000;
        starts[3] = 25'h300000;

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_prog_we", prog_we, 0);
        chk("rst_prog_addr", prog_addr, 0);
        chk("rst_prog_data", prog_data, 0);
        chk("rst_prog_mask", prog_mask, 0);
        chk("rst_prog_ba", prog_ba, 0);
        chk("rst_prom_we", prom_we, 0);
        chk("rst_prom_addr", prom_addr, 0);
        chk("rst_prom_data", prom_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", dwnld_busy, 0);
        downloading = 1'b1;
        #1 chk("busy_dl", dwnld_busy, 1);
        @(negedge clk);

        // Two bytes of the first word, with latency check
        send(25'h0, 8'hA5);
        chk("latency_k", prog_we, 0);
        @(negedge clk);
        chk("latency_k1", prog_we, 1);
        serve(1'b0);
        send(25'h1, 8'h3C);
        serve(1'b0);

        // Bank 1 decode, and the same byte on a single-bank instance
        send(25'h100003, 8'h77);
        @(negedge clk);
        chk("b1_ba", b1_prog_ba, 0);
        chk("b1_addr", b1_prog_addr, 22'h080001);
        chk("b1_mask", b1_prog_mask, 2'b01);
        serve(1'b0);

        // PROM byte
        send(PROM + 25'd5, 8'h5E);
        @(negedge clk);
        chk("prom_pulse_end", prom_we, 0);
        chk("prom_no_prog_we", prog_we, 0);

        // Randomized bursts, never exceeding the FIFO capacity
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, CAP);
            for (int k = 0; k < n; k++) begin
                kind = $urandom_range(0, 4);
                if (kind == 4) a = PROM + 25'($urandom_range(0, 255));
                else           a = starts[kind] + 25'($urandom_range(0, 25'hFFFFF));
                send(a, 8'($urandom));
            end
            while (q.size() > 0) serve(1'b0);
        end
        chk("no_overflow_yet", overflow, 0);

        // Overflow: four accepted, fifth dropped
        for (int k = 0; k < 5; k++) send(25'h200000 + 25'(k), 8'(8'h10 + k));
        chk("ovf_q_model", q.size(), CAP);
        chk("overflow_set", overflow, 1);
        // Push coinciding with a pop on a full FIFO is accepted
        h = q.pop_front();
        chk("full_head_addr", prog_addr, h.wa);
        chk("full_head_data", prog_data, {h.d, h.d});
        ioctl_addr = 25'h300010;
        ioctl_data = 8'hC7;
        ioctl_wr   = 1'b1;
        prog_rdy   = 1'b1;
        q.push_back(ref_wr(25'h300010, 8'hC7, 4));
        @(negedge clk);
        ioctl_wr   = 1'b0;
        prog_rdy   = 1'b0;
        repeat (4) serve(1'b0);
        chk("ovf_drained_idle", dwnld_busy, 1);
        downloading = 1'b0;
        @(negedge clk);
        chk("overflow_sticky", overflow, 1);
        downloading = 1'b1;
        @(negedge clk);
        chk("overflow_cleared", overflow, 0);

        // Drain after the download window closes
        for (int k = 0; k < 3; k++) send(25'h000100 + 25'(k), 8'($urandom));
        downloading = 1'b0;
        serve(1'b1);
        serve(1'b1);
        serve(1'b1);
        chk("busy_after_drain", dwnld_busy, 0);

        // Bytes outside the download window are ignored
        send(25'h10, 8'h99);
        repeat (3) @(negedge clk);
        chk("ignored_we", prog_we, 0);
        chk("ignored_busy", dwnld_busy, 0);

        // Reset during WAIT aborts the write immediately
        downloading = 1'b1;
        send(25'h40, 8'h11);
        @(negedge clk);
        chk("wait_we", prog_we, 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_abort_we", prog_we, 0);
        chk("rst_abort_addr", prog_addr, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        downloading = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_drain_we", prog_we, 0);
        chk("rst_no_drain_busy", dwnld_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
